qcldpc_enc_sched: RTL and testbench



---
 rtl/qcldpc_pkg.sv | 37 +++
 rtl/qcldpc_enc_sched_if.sv | 41 ++++
 rtl/qcldpc_zsel_decode.sv | 16 +
 rtl/qcldpc_enc_sched.sv | 148 ++++++++++++++
 tb/tb_qcldpc_enc_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qcldpc_pkg.sv
// Shared types and elaboration-time helpers for the QC-LDPC encoder control path.
package qcldpc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INFO,
    ST_PARITY,
    ST_OUT
  } state_t;

  localparam int NUM_COLS_DEFAULT = 24;

  function automatic int num_cols(input int num_info, input int num_parity);
    return num_info + num_parity;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One address slot per (Z, block-column) pair in the prototype ROM.
  function automatic int rom_addr_w(input int num_z, input int num_info, input int num_parity);
    int w;
    w = $clog2(num_z * num_cols(num_info, num_parity));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_enc_sched_if.sv
// Control and handshake bundle between the upstream source/datapath and the encoder scheduler.
interface qcldpc_enc_sched_if #(
  parameter int NUM_OF_SUPPORTED_Z           = 3,
  parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4
);

  localparam int ADDR_W = qcldpc_pkg::rom_addr_w(NUM_OF_SUPPORTED_Z,
                                                 NUM_INFO_BLKS_PER_CODE_BLK,
                                                 NUM_PARITY_BLKS_PER_CODE_BLK);
  localparam int PIDX_W = qcldpc_pkg::idx_w(NUM_PARITY_BLKS_PER_CODE_BLK);

  logic                          start;
  logic [NUM_OF_SUPPORTED_Z-1:0] req_z;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_OF_SUPPORTED_Z-1:0] z_sel;
  logic [ADDR_W-1:0]             rom_addr;
  logic                          acc_clr;
  logic                          acc_en;
  logic                          par_en;
  logic [PIDX_W-1:0]             par_idx;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic                          done;
  logic                          err_z;

  modport master (
    output start, req_z, in_valid, out_ready,
    input  in_ready, z_sel, rom_addr, acc_clr, acc_en, par_en, par_idx,
           out_valid, busy, done, err_z
  );

  modport slave (
    input  start, req_z, in_valid, out_ready,
    output in_ready, z_sel, rom_addr, acc_clr, acc_en, par_en, par_idx,
           out_valid, busy, done, err_z
  );

endinterface

// File: rtl/qcldpc_zsel_decode.sv
// One-hot Z select validity check and index encode, shared with the ROM front end.
module qcldpc_zsel_decode
  import qcldpc_pkg::*;
#(
  parameter int NZ    = 3,
  parameter int IDX_W = idx_w(NZ)
) (
  input  logic [NZ-1:0]    onehot,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  assign valid = $onehot(onehot);
  assign idx   = IDX_W'(onehot_to_idx(32'(onehot)));

endmodule

// File: rtl/qcldpc_enc_sched.sv
// Sequencing FSM for the QC-LDPC encoder: latches Z, walks info then parity ROM columns,
// strobes the accumulators one cycle behind each address, and holds the codeword for hand-off.
module qcldpc_enc_sched
  import qcldpc_pkg::*;
#(
  parameter int NUM_OF_SUPPORTED_Z           = 3,
  parameter int HIGHEST_SUPPORTED_Z_VAL      = 81,
  parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4,
  parameter int LEVEL_OF_PARALLELIZATION     = 1
) (
  input logic              clk,
  input logic              rst_n,
  qcldpc_enc_sched_if.slave bus
);

  localparam int NZ     = NUM_OF_SUPPORTED_Z;
  localparam int NI     = NUM_INFO_BLKS_PER_CODE_BLK;
  localparam int NP     = NUM_PARITY_BLKS_PER_CODE_BLK;
  localparam int PLVL   = LEVEL_OF_PARALLELIZATION;
  localparam int NCOLS  = num_cols(NI, NP);
  localparam int ADDR_W = rom_addr_w(NZ, NI, NP);
  localparam int ZIDX_W = idx_w(NZ);
  localparam int PIDX_W = idx_w(NP);
  localparam int COL_W  = $clog2(NI + 1);

  if (PLVL < 1 || (NI % PLVL) != 0) begin : g_chk_plvl
    $error("LEVEL_OF_PARALLELIZATION must divide NUM_INFO_BLKS_PER_CODE_BLK");
  end
  if (HIGHEST_SUPPORTED_Z_VAL < 1 || NZ < 1) begin : g_chk_z
    $error("Z configuration must be non-empty");
  end

  logic              z_valid;
  logic [ZIDX_W-1:0] z_idx_dec;

  qcldpc_zsel_decode #(
    .NZ    (NZ),
    .IDX_W (ZIDX_W)
  ) u_zsel_decode (
    .onehot (bus.req_z),
    .valid  (z_valid),
    .idx    (z_idx_dec)
  );

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [PIDX_W-1:0] p;
  logic              drain;
  logic [ADDR_W-1:0] base;

  logic [COL_W-1:0]  col_next;
  logic [PIDX_W-1:0] p_next;
  logic [ADDR_W-1:0] start_base;

  assign col_next   = col + COL_W'(PLVL);
  assign p_next     = p + PIDX_W'(1);
  assign start_base = ADDR_W'(int'(z_idx_dec) * NCOLS);

  // Strobes default low each cycle; acc_en/par_en are issued one cycle after
  // the rom_addr they belong to, matching the ROM's single-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      col           <= '0;
      p             <= '0;
      drain         <= 1'b0;
      base          <= '0;
      bus.in_ready  <= 1'b0;
      bus.z_sel     <= '0;
      bus.rom_addr  <= '0;
      bus.acc_clr   <= 1'b0;
      bus.acc_en    <= 1'b0;
      bus.par_en    <= 1'b0;
      bus.par_idx   <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err_z     <= 1'b0;
    end else begin
      bus.acc_clr <= 1'b0;
      bus.acc_en  <= 1'b0;
      bus.par_en  <= 1'b0;
      bus.done    <= 1'b0;
      bus.err_z   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (z_valid) begin
              bus.z_sel    <= bus.req_z;
              base         <= start_base;
              col          <= '0;
              p            <= '0;
              drain        <= 1'b0;
              bus.rom_addr <= start_base;
              bus.in_ready <= 1'b1;
              bus.acc_clr  <= 1'b1;
              bus.busy     <= 1'b1;
              state        <= ST_INFO;
            end else begin
              bus.err_z <= 1'b1;
            end
          end
        end
        ST_INFO: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.acc_en <= 1'b1;
            if (col_next == COL_W'(NI)) begin
              col          <= '0;
              bus.in_ready <= 1'b0;
              bus.rom_addr <= base + ADDR_W'(NI);
              state        <= ST_PARITY;
            end else begin
              col          <= col_next;
              bus.rom_addr <= base + ADDR_W'(col_next);
            end
          end
        end
        ST_PARITY: begin
          if (drain) begin
            drain         <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= ST_OUT;
          end else begin
            bus.par_en  <= 1'b1;
            bus.par_idx <= p;
            if (p == PIDX_W'(NP - 1)) begin
              drain <= 1'b1;
            end else begin
              p            <= p_next;
              bus.rom_addr <= base + ADDR_W'(NI) + ADDR_W'(p_next);
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qcldpc_enc_sched.sv
// Directed self-checking bench for qcldpc_enc_sched: default instance plus a PLvl=2 instance.
module tb_qcldpc_enc_sched;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  qcldpc_enc_sched_if bus_a ();
  qcldpc_enc_sched_if bus_b ();

  qcldpc_enc_sched dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  qcldpc_enc_sched #(
    .LEVEL_OF_PARALLELIZATION (2)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the codeword, then complete the output handshake on instance A.
  task automatic finish_codeword();
    int n;
    n = 0;
    bus_a.in_valid = 1'b1;
    while (!bus_a.out_valid && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (bus_a.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL finish_timeout: out_valid=%b after %0d cycles, required 1", bus_a.out_valid, n);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    step();
    checks++;
    if (bus_a.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL finish_done: done=%b required 1", bus_a.done);
    end
    bus_a.out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus_a.in_ready, bus_a.z_sel, bus_a.rom_addr, bus_a.acc_clr, bus_a.acc_en, bus_a.par_en,
         bus_a.par_idx, bus_a.out_valid, bus_a.busy, bus_a.done, bus_a.err_z} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_a: some output nonzero, rom_addr=%0d in_ready=%b busy=%b",
               bus_a.rom_addr, bus_a.in_ready, bus_a.busy);
    end
    checks++;
    if ({bus_b.in_ready, bus_b.z_sel, bus_b.rom_addr, bus_b.acc_clr, bus_b.acc_en, bus_b.par_en,
         bus_b.par_idx, bus_b.out_valid, bus_b.busy, bus_b.done, bus_b.err_z} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_b: some output nonzero, rom_addr=%0d in_ready=%b busy=%b",
               bus_b.rom_addr, bus_b.in_ready, bus_b.busy);
    end
  endtask

  task automatic test_illegal_z();
    logic [2:0] bad [2];
    bad[0] = 3'b000;
    bad[1] = 3'b110;
    for (int k = 0; k < 2; k++) begin
      bus_a.req_z = bad[k];
      bus_a.start = 1'b1;
      step();
      bus_a.start = 1'b0;
      checks++;
      if (bus_a.err_z !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.z_sel !== 3'b000 || bus_a.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_z_%0d: err_z=%b busy=%b z_sel=%b in_ready=%b, required 1 0 000 0",
                 k, bus_a.err_z, bus_a.busy, bus_a.z_sel, bus_a.in_ready);
      end
      step();
      checks++;
      if (bus_a.err_z !== 1'b0 || bus_a.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_z_pulse_%0d: err_z=%b busy=%b, required 0 0", k, bus_a.err_z, bus_a.busy);
      end
    end
  endtask

  task automatic test_z54();
    int acc_cnt;
    int par_cnt;
    acc_cnt = 0;
    par_cnt = 0;
    bus_a.req_z    = 3'b010;
    bus_a.in_valid = 1'b1;
    bus_a.start    = 1'b1;
    step();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.z_sel !== 3'b010) begin
      errors++;
      $display("[TB] FAIL z54_zsel: z_sel=%b required 010", bus_a.z_sel);
    end
    for (int c = 1; c <= 26; c++) begin
      if (bus_a.acc_en) acc_cnt++;
      if (bus_a.par_en) par_cnt++;
      checks++;
      if (bus_a.in_ready !== (c <= 20) || bus_a.acc_clr !== (c == 1) || bus_a.busy !== 1'b1 ||
          bus_a.acc_en !== (c >= 2 && c <= 21) || bus_a.par_en !== (c >= 22 && c <= 25) ||
          bus_a.out_valid !== (c == 26)) begin
        errors++;
        $display("[TB] FAIL z54_strobes_c%0d: rdy=%b clr=%b acc=%b par=%b ov=%b busy=%b", c,
                 bus_a.in_ready, bus_a.acc_clr, bus_a.acc_en, bus_a.par_en, bus_a.out_valid, bus_a.busy);
      end
      if (c <= 24) begin
        checks++;
        if (bus_a.rom_addr !== 7'(23 + c)) begin
          errors++;
          $display("[TB] FAIL z54_rom_addr_c%0d: rom_addr=%0d required %0d", c, bus_a.rom_addr, 23 + c);
        end
      end
      if (c >= 22 && c <= 25) begin
        checks++;
        if (bus_a.par_idx !== 2'(c - 22)) begin
          errors++;
          $display("[TB] FAIL z54_par_idx_c%0d: par_idx=%0d required %0d", c, bus_a.par_idx, c - 22);
        end
      end
      if (c < 26) step();
    end
    checks++;
    if (acc_cnt != 20 || par_cnt != 4) begin
      errors++;
      $display("[TB] FAIL z54_counts: acc_en=%0d par_en=%0d, required 20 and 4", acc_cnt, par_cnt);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL z54_handshake: done=%b out_valid=%b busy=%b, required 1 0 0",
               bus_a.done, bus_a.out_valid, bus_a.busy);
    end
    step();
    checks++;
    if (bus_a.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL z54_done_pulse: done=%b required 0", bus_a.done);
    end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    bus_a.req_z    = 3'b010;
    bus_a.in_valid = 1'b1;
    bus_a.start    = 1'b1;
    step();
    bus_a.start = 1'b0;
    while (!bus_a.out_valid && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n != 25) begin
      errors++;
      $display("[TB] FAIL bp_latency: out_valid after %0d extra cycles, required 25", n);
    end
    bus_a.req_z = 3'b001;
    bus_a.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.done !== 1'b0 || bus_a.z_sel !== 3'b010) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: out_valid=%b in_ready=%b done=%b z_sel=%b, required 1 0 0 010",
                 k, bus_a.out_valid, bus_a.in_ready, bus_a.done, bus_a.z_sel);
      end
    end
    bus_a.start     = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: done=%b out_valid=%b busy=%b, required 1 0 0",
               bus_a.done, bus_a.out_valid, bus_a.busy);
    end
  endtask

  // Starts in the cycle where done is high, i.e. immediately after test_backpressure.
  task automatic test_back_to_back();
    bus_a.req_z = 3'b001;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.in_ready !== 1'b1 || bus_a.acc_clr !== 1'b1 || bus_a.rom_addr !== 7'd0 ||
        bus_a.z_sel !== 3'b001 || bus_a.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_start: in_ready=%b acc_clr=%b rom_addr=%0d z_sel=%b done=%b, required 1 1 0 001 0",
               bus_a.in_ready, bus_a.acc_clr, bus_a.rom_addr, bus_a.z_sel, bus_a.done);
    end
    finish_codeword();
  endtask

  task automatic test_stall();
    int  beats;
    int  acc_cnt;
    bit  prev_v;
    bit  v;
    beats   = 0;
    acc_cnt = 0;
    prev_v  = 1'b0;
    bus_a.req_z = 3'b001;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      v = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
      bus_a.in_valid = v;
      if (bus_a.out_valid) break;
      if (bus_a.acc_en) acc_cnt++;
      if (bus_a.in_ready) begin
        checks++;
        if (bus_a.rom_addr !== 7'(beats)) begin
          errors++;
          $display("[TB] FAIL stall_rom_addr_c%0d: rom_addr=%0d required %0d", c, bus_a.rom_addr, beats);
        end
      end
      checks++;
      if (bus_a.acc_en !== prev_v) begin
        errors++;
        $display("[TB] FAIL stall_acc_en_c%0d: acc_en=%b required %b", c, bus_a.acc_en, prev_v);
      end
      prev_v = v && bus_a.in_ready;
      if (v && bus_a.in_ready) beats++;
      step();
    end
    checks++;
    if (acc_cnt != 20 || beats != 20 || bus_a.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_totals: acc_en=%0d beats=%0d out_valid=%b, required 20 20 1",
               acc_cnt, beats, bus_a.out_valid);
    end
    finish_codeword();
  endtask

  task automatic test_plvl2();
    bus_b.req_z    = 3'b100;
    bus_b.in_valid = 1'b1;
    bus_b.start    = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (bus_b.in_ready !== (c <= 10) || bus_b.acc_en !== (c >= 2 && c <= 11) ||
          bus_b.par_en !== (c >= 12 && c <= 15) || bus_b.out_valid !== (c == 16)) begin
        errors++;
        $display("[TB] FAIL plvl2_strobes_c%0d: rdy=%b acc=%b par=%b ov=%b", c,
                 bus_b.in_ready, bus_b.acc_en, bus_b.par_en, bus_b.out_valid);
      end
      if (c <= 11) begin
        checks++;
        if (bus_b.rom_addr !== ((c <= 10) ? 7'(46 + 2 * c) : 7'd68)) begin
          errors++;
          $display("[TB] FAIL plvl2_rom_addr_c%0d: rom_addr=%0d required %0d", c, bus_b.rom_addr,
                   (c <= 10) ? 46 + 2 * c : 68);
        end
      end
      if (c < 16) step();
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    step();
    bus_b.out_ready = 1'b0;
    checks++;
    if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL plvl2_done: done=%b busy=%b, required 1 0", bus_b.done, bus_b.busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus_a.req_z    = 3'b010;
    bus_a.in_valid = 1'b1;
    bus_a.start    = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    checks++;
    if (bus_a.rom_addr !== 7'd31 || bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: rom_addr=%0d in_ready=%b, required 31 1", bus_a.rom_addr, bus_a.in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.in_ready, bus_a.z_sel, bus_a.rom_addr, bus_a.acc_clr, bus_a.acc_en, bus_a.par_en,
         bus_a.par_idx, bus_a.out_valid, bus_a.busy, bus_a.done, bus_a.err_z} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_async: rom_addr=%0d in_ready=%b acc_en=%b busy=%b z_sel=%b, required all 0",
               bus_a.rom_addr, bus_a.in_ready, bus_a.acc_en, bus_a.busy, bus_a.z_sel);
    end
    bus_a.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus_a.req_z = 3'b001;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.acc_clr !== 1'b1 || bus_a.rom_addr !== 7'd0 || bus_a.in_ready !== 1'b1 ||
        bus_a.busy !== 1'b1 || bus_a.acc_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_restart: acc_clr=%b rom_addr=%0d in_ready=%b busy=%b acc_en=%b, required 1 0 1 1 0",
               bus_a.acc_clr, bus_a.rom_addr, bus_a.in_ready, bus_a.busy, bus_a.acc_en);
    end
    finish_codeword();
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    rst_n           = 1'b0;
    bus_a.start     = 1'b0;
    bus_a.req_z     = 3'b000;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.start     = 1'b0;
    bus_b.req_z     = 3'b000;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_illegal_z();
    test_z54();
    test_backpressure();
    test_back_to_back();
    test_stall();
    test_plvl2();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
